varint_arb: RTL and testbench
=============================

# varint_arb

Round-robin arbiter and sequencer that shares the single varint encoder FSM between `NUM_REQ` field producers. It accepts one 32- or 64-bit value plus field index per grant and serialises it into the varint input FIFO. A 32-bit value becomes one word with size flag 0. A 64-bit value becomes the low word with size flag 1, then the high word with size flag 0, which is the ordering the encoder expects. It sits between the field-extraction stages and the varint input FIFO, and reports when the whole varint path is idle.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester channels (2..8).
- `IDX_W`, 8: width of the field index.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, NUM_REQ: requester i has a value pending.
- `req_is64`, in, NUM_REQ: value is 64-bit.
- `req_data`, in, NUM_REQ*64: value for requester i, in bits [64i+63:64i]; upper 32 bits are ignored when `req_is64[i]`=0.
- `req_index`, in, NUM_REQ*IDX_W: field index for requester i.
- `req_ack`, out, NUM_REQ: one-hot, one-cycle capture strobe.
- `varint_in_fifo_full`, in, 1: encoder input FIFO full.
- `varint_in_fifo_empty`, in, 1: encoder input FIFO empty.
- `encoding`, in, 1: encoder FSM busy.
- `varint_in_fifo_push`, out, 1: push word.
- `varint_in_data`, out, 32: word to push.
- `varint_in_size_d`, out, 1: size flag pushed with the word.
- `varint_in_index_d`, out, IDX_W: index pushed with the word.
- `idle`, out, 1: no pending grant, FIFO empty, encoder not encoding.

## Operation
- States: `ARB`, `PUSH_LO`, `PUSH_HI`. Reset state is `ARB`.
- `ARB`:
  - If any `req_valid` is set, pick the winner with the round-robin search starting at `last+1` (mod NUM_REQ).
  - Assert `req_ack[winner]`.
  - Capture data, is64 and index into holding registers.
  - Set `last` to the winner and go to `PUSH_LO`.
  - If no `req_valid` is set, stay in `ARB`.
- `PUSH_LO`:
  - If `varint_in_fifo_full`=1, stall with no push.
  - Otherwise push `data[31:0]` with size flag = is64 and the held index.
  - Then go to `PUSH_HI` if is64, else `ARB`.
- `PUSH_HI`:
  - Stall while the FIFO is full.
  - Otherwise push `data[63:32]` with size flag 0 and the same index, then go to `ARB`.
- `varint_in_data`, `varint_in_size_d` and `varint_in_index_d` are driven from the holding registers and are valid only while `varint_in_fifo_push`=1.
- `idle` = (state==`ARB`) & ~|`req_valid` & `varint_in_fifo_empty` & ~`encoding`.
- Requester rules:
  - Hold valid, data, is64 and index stable until ack.
  - In the cycle after ack, either deassert valid or present the next value.
  - A requester that keeps valid asserted is re-granted no sooner than after every other active requester has had one grant.
- The two words of a 64-bit value are never interleaved with another requester's words.

## Timing
- Reset values:
  - `req_ack`=0, `varint_in_fifo_push`=0, `varint_in_size_d`=0, `varint_in_data`=0, `varint_in_index_d`=0.
  - `last`=NUM_REQ-1, so requester 0 wins first.
  - `idle` follows its equation from reset.
- Ack is combinational in `ARB` from registered state and `req_valid`, asserted in the same cycle the request is seen.
- Minimum spacing:
  - 32-bit grant to FIFO push: 1 cycle.
  - Back-to-back 32-bit grants: one grant every 2 cycles.
  - 64-bit value: grant plus 2 push cycles, so 3 cycles per value.
- FIFO full is sampled in the push cycle. When it is full, nothing is pushed and the state holds; the push occurs in the first cycle full=0.
- Ack never occurs while in `PUSH_LO` or `PUSH_HI`.
- Reset mid-operation:
  - Any held value is discarded, including a 64-bit value whose low word was already pushed.
  - The FIFO and encoder are reset by the same `reset`, so no orphaned low word survives.

## Configuration
- `VARINT_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; the `last` register is not built.
- `VARINT_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described.

## Structure
- `varint_pkg` holds:
  - the state enum `varint_arb_state_t` (`ARB`, `PUSH_LO`, `PUSH_HI`);
  - the default `NUM_REQ` and `IDX_W`;
  - the size-flag constants `VARINT_SZ_LAST`=0 and `VARINT_SZ_MORE`=1.
- Sub-module `varint_rr_pick`: combinational one-hot winner from the request vector and the `last` pointer, with the fixed-priority variant under the macro.

## Test plan
- Single 32-bit request: req0 with data 0x0000_0000_0000_012C, index 5 → ack0 in cycle 1; one push in cycle 2 with data 0x0000012C, size 0, index 5; idle returns once the encoder finishes.
- 64-bit request: req2 with 0x1234_5678_9ABC_DEF0, index 7 → pushes 0x9ABCDEF0/size 1 then 0x12345678/size 0 on consecutive cycles, both with index 7.
- All four requesters valid continuously with 32-bit values → grant order 0,1,2,3,0,1… and one push every 2 cycles; with `VARINT_ARB_FIXED_PRIO_EN`, req0 wins every grant.
- FIFO full asserted for 3 cycles between the low and high words of a 64-bit value → no push and no ack during the stall; the high word is pushed in the first non-full cycle; no other requester's word appears between the two words.
- `reset` asserted in `PUSH_HI` → next cycle: state `ARB`, all outputs 0, and the next grant goes to req0.
- Boundary: `NUM_REQ`=2 with only req1 valid → repeated grants to req1 with no dead cycles beyond the 2-cycle spacing.

Source files
------------

// File: rtl/varint_pkg.sv
// varint_pkg: shared types and constants for the varint arbiter slice.
// Contains the arbiter state encoding, default sizing and the size-flag values
// pushed alongside each 32-bit word into the varint input FIFO.
package varint_pkg;

    localparam int VARINT_NUM_REQ_DEF = 4;
    localparam int VARINT_IDX_W_DEF   = 8;

    // Size flag: MORE marks the low word of a 64-bit value, LAST the final word.
    localparam logic VARINT_SZ_LAST = 1'b0;
    localparam logic VARINT_SZ_MORE = 1'b1;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        PUSH_LO = 2'd1,
        PUSH_HI = 2'd2
    } varint_arb_state_t;

endpackage : varint_pkg

// File: rtl/varint_rr_pick.sv
// varint_rr_pick: combinational one-hot winner selection.
// Default: round-robin search starting one past the last winner.
// With VARINT_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and last_i is ignored.
module varint_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_o
);

`ifdef VARINT_ARB_FIXED_PRIO_EN
    // Lowest-indexed valid request wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                winner_o   = PTR_W'(k);
            end else begin
                any_o = any_o;
            end
        end
    end
`else
    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;

    // Walk the requests from last+1 around to last; first valid one wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        any_o    = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_s = {1'b0, last_i} + (PTR_W+1)'(k);
            if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (PTR_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PTR_W-1:0];
            if (!any_o && req_i[idx_s]) begin
                any_o          = 1'b1;
                grant_o[idx_s] = 1'b1;
                winner_o       = idx_s;
            end else begin
                any_o = any_o;
            end
        end
    end
`endif

endmodule : varint_rr_pick

// File: rtl/varint_arb.sv
// varint_arb: shares the varint encoder input FIFO between NUM_REQ producers.
// One grant per value; a 64-bit value is pushed as low word (size MORE) then
// high word (size LAST) with no other requester's words in between.
// Build option: VARINT_ARB_FIXED_PRIO_EN selects fixed priority and drops the
// round-robin pointer register.
module varint_arb
    import varint_pkg::*;
#(
    parameter int NUM_REQ = VARINT_NUM_REQ_DEF,
    parameter int IDX_W   = VARINT_IDX_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_is64,
    input  logic [NUM_REQ*64-1:0]    req_data,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       req_ack,
    input  logic                     varint_in_fifo_full,
    input  logic                     varint_in_fifo_empty,
    input  logic                     encoding,
    output logic                     varint_in_fifo_push,
    output logic [31:0]              varint_in_data,
    output logic                     varint_in_size_d,
    output logic [IDX_W-1:0]         varint_in_index_d,
    output logic                     idle
);

    localparam int PTR_W = $clog2(NUM_REQ);

    varint_arb_state_t state_q, state_d;
    logic [63:0]       data_q, data_d;
    logic              is64_q, is64_d;
    logic [IDX_W-1:0]  index_q, index_d;

    logic [PTR_W-1:0]   last_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   winner_s;
    logic               any_s;

    logic [63:0]      sel_data_s;
    logic             sel_is64_s;
    logic [IDX_W-1:0] sel_index_s;

`ifdef VARINT_ARB_FIXED_PRIO_EN
    assign last_s = '0;
`else
    logic [PTR_W-1:0] last_q, last_d;
    assign last_s = last_q;
`endif

    varint_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i    (req_valid),
        .last_i   (last_s),
        .grant_o  (grant_s),
        .winner_o (winner_s),
        .any_o    (any_s)
    );

    // Route the granted requester's payload onto the capture bus.
    always_comb begin
        sel_data_s  = 64'd0;
        sel_is64_s  = 1'b0;
        sel_index_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_data_s  = req_data[i*64 +: 64];
                sel_is64_s  = req_is64[i];
                sel_index_s = req_index[i*IDX_W +: IDX_W];
            end else begin
                sel_data_s  = sel_data_s;
            end
        end
    end

    // Next-state, capture and strobe logic; ack only in ARB, push only when not full.
    always_comb begin
        state_d             = state_q;
        data_d              = data_q;
        is64_d              = is64_q;
        index_d             = index_q;
`ifndef VARINT_ARB_FIXED_PRIO_EN
        last_d              = last_q;
`endif
        req_ack             = '0;
        varint_in_fifo_push = 1'b0;
        if (reset) begin
            state_d = ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (any_s) begin
                        req_ack = grant_s;
                        data_d  = sel_data_s;
                        is64_d  = sel_is64_s;
                        index_d = sel_index_s;
`ifndef VARINT_ARB_FIXED_PRIO_EN
                        last_d  = winner_s;
`endif
                        state_d = PUSH_LO;
                    end else begin
                        state_d = ARB;
                    end
                end
                PUSH_LO: begin
                    if (varint_in_fifo_full) begin
                        state_d = PUSH_LO;
                    end else begin
                        varint_in_fifo_push = 1'b1;
                        state_d = is64_q ? PUSH_HI : ARB;
                    end
                end
                PUSH_HI: begin
                    if (varint_in_fifo_full) begin
                        state_d = PUSH_HI;
                    end else begin
                        varint_in_fifo_push = 1'b1;
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    // Word, size flag and index presented to the FIFO come from the holding registers.
    always_comb begin
        if (state_q == PUSH_HI) begin
            varint_in_data   = data_q[63:32];
            varint_in_size_d = VARINT_SZ_LAST;
        end else begin
            varint_in_data   = data_q[31:0];
            varint_in_size_d = ((state_q == PUSH_LO) && is64_q) ? VARINT_SZ_MORE : VARINT_SZ_LAST;
        end
        varint_in_index_d = index_q;
    end

    assign idle = (state_q == ARB) & ~(|req_valid) & varint_in_fifo_empty & ~encoding;

    // State and holding registers; reset discards any partially pushed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            data_q  <= 64'd0;
            is64_q  <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            is64_q  <= is64_d;
            index_q <= index_d;
        end
    end

`ifndef VARINT_ARB_FIXED_PRIO_EN
    // Round-robin pointer; resets to the top so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule : varint_arb

// File: tb/tb_varint_arb.sv
// tb_varint_arb: table-driven directed bench for varint_arb (NUM_REQ=4),
// plus a hand-written sequence on a NUM_REQ=2 instance.
module tb_varint_arb;

`ifdef VARINT_ARB_FIXED_PRIO_EN
    localparam bit FX = 1'b1;
`else
    localparam bit FX = 1'b0;
`endif

    localparam logic [63:0] D0 = 64'h0000_0000_0000_012C;
    localparam logic [63:0] D1 = 64'h1111_1111_AAAA_0001;
    localparam logic [63:0] D2 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] D3 = 64'h3333_3333_0000_0303;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_is64;
    logic [255:0] req_data;
    logic [31:0] req_index;
    logic [3:0]  req_ack;
    logic        full, empty, enc;
    logic        push;
    logic [31:0] wdata;
    logic        wsize;
    logic [7:0]  widx;
    logic        idle;

    logic [1:0]   v2, is2, ack2;
    logic [127:0] d2;
    logic [15:0]  ix2;
    logic         push2, size2, idle2;
    logic [31:0]  wdata2;
    logic [7:0]   widx2;

    int n_cmp  = 0;
    int n_fail = 0;

    varint_arb #(.NUM_REQ(4), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_is64(req_is64),
        .req_data(req_data), .req_index(req_index), .req_ack(req_ack),
        .varint_in_fifo_full(full), .varint_in_fifo_empty(empty), .encoding(enc),
        .varint_in_fifo_push(push), .varint_in_data(wdata), .varint_in_size_d(wsize),
        .varint_in_index_d(widx), .idle(idle)
    );

    varint_arb #(.NUM_REQ(2), .IDX_W(8)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_is64(is2),
        .req_data(d2), .req_index(ix2), .req_ack(ack2),
        .varint_in_fifo_full(1'b0), .varint_in_fifo_empty(1'b1), .encoding(1'b0),
        .varint_in_fifo_push(push2), .varint_in_data(wdata2), .varint_in_size_d(size2),
        .varint_in_index_d(widx2), .idle(idle2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, chk, zdat;
        logic [3:0]  vld, is64;
        logic        full, empty, enc;
        logic [3:0]  ack;
        logic        push;
        logic [31:0] data;
        logic        size;
        logic [7:0]  idx;
        logic        idle;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic chk, input logic zdat,
                       input logic [3:0] vld, input logic [3:0] is64,
                       input logic fl, input logic em, input logic en,
                       input logic [3:0] ack, input logic ps, input logic [31:0] dat,
                       input logic sz, input logic [7:0] ix, input logic idl);
        vec_t v;
        v.rst = rst; v.chk = chk; v.zdat = zdat; v.vld = vld; v.is64 = is64;
        v.full = fl; v.empty = em; v.enc = en; v.ack = ack; v.push = ps;
        v.data = dat; v.size = sz; v.idx = ix; v.idle = idl;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 4'd0; req_is64 = 4'd0;
        full = 1'b0; empty = 1'b1; enc = 1'b0;
        req_data  = {D3, D2, D1, D0};
        req_index = {8'd33, 8'd7, 8'd11, 8'd5};
        v2 = 2'b00; is2 = 2'b00;
        d2 = {64'h0000_0000_CAFE_0042, 64'h0000_0000_0BAD_0000};
        ix2 = {8'd9, 8'd4};

        //   rst chk zd vld    is64   fl em en | ack    ps data           sz idx     idle
        add(1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        add(1'b1,1'b1,1'b1,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        // single 32-bit request from req0
        add(1'b0,1'b1,1'b1,4'b0001,4'b0000,1'b0,1'b1,1'b0, 4'b0001,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h0000012C,1'b0,8'd5,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b0,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b1, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        // 64-bit request from req2
        add(1'b0,1'b1,1'b0,4'b0100,4'b0100,1'b0,1'b1,1'b0, 4'b0100,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h9ABCDEF0,1'b1,8'd7,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h12345678,1'b0,8'd7,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        // reset, then all four valid with 32-bit values
        add(1'b1,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        add(1'b0,1'b1,1'b1,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0001,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h0000012C,1'b0,8'd5,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, FX ? 4'b0001 : 4'b0010,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,FX ? 32'h0000012C : 32'hAAAA0001,1'b0,FX ? 8'd5 : 8'd11,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, FX ? 4'b0001 : 4'b0100,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,FX ? 32'h0000012C : 32'h9ABCDEF0,1'b0,FX ? 8'd5 : 8'd7,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, FX ? 4'b0001 : 4'b1000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,FX ? 32'h0000012C : 32'h00000303,1'b0,FX ? 8'd5 : 8'd33,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0001,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h0000012C,1'b0,8'd5,1'b0);
        // 64-bit value with FIFO full between its words, others waiting
        add(1'b0,1'b1,1'b0,4'b0100,4'b0100,1'b0,1'b1,1'b0, 4'b0100,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h9ABCDEF0,1'b1,8'd7,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b1,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b1,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b1,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h12345678,1'b0,8'd7,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b0,1'b1,1'b0, FX ? 4'b0001 : 4'b1000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b1,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b1011,4'b0100,1'b0,1'b1,1'b0, 4'b0000,1'b1,FX ? 32'h0000012C : 32'h00000303,1'b0,FX ? 8'd5 : 8'd33,1'b0);
        // reset while in PUSH_HI
        add(1'b0,1'b1,1'b0,4'b0100,4'b0100,1'b0,1'b1,1'b0, 4'b0100,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h9ABCDEF0,1'b1,8'd7,1'b0);
        add(1'b1,1'b0,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        add(1'b0,1'b1,1'b1,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);
        add(1'b0,1'b1,1'b1,4'b1111,4'b0000,1'b0,1'b1,1'b0, 4'b0001,1'b0,32'h0,1'b0,8'd0,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b1,32'h0000012C,1'b0,8'd5,1'b0);
        add(1'b0,1'b1,1'b0,4'b0000,4'b0000,1'b0,1'b1,1'b0, 4'b0000,1'b0,32'h0,1'b0,8'd0,1'b1);

        for (int i = 0; i < tv.size(); i++) begin
            reset     = tv[i].rst;
            req_valid = tv[i].vld;
            req_is64  = tv[i].is64;
            full      = tv[i].full;
            empty     = tv[i].empty;
            enc       = tv[i].enc;
            #3;
            if (tv[i].chk) begin
                check("ack",  i, {28'd0, req_ack}, {28'd0, tv[i].ack});
                check("push", i, {31'd0, push},    {31'd0, tv[i].push});
                check("idle", i, {31'd0, idle},    {31'd0, tv[i].idle});
                if (tv[i].push || tv[i].zdat) begin
                    check("data", i, wdata,             tv[i].data);
                    check("size", i, {31'd0, wsize},   {31'd0, tv[i].size});
                    check("index", i, {24'd0, widx},   {24'd0, tv[i].idx});
                end
            end
            @(posedge clk);
            #1;
        end

        // NUM_REQ=2, only req1 valid: grant every other cycle, push in between
        v2 = 2'b10;
        for (int k = 0; k < 8; k++) begin
            #3;
            if ((k % 2) == 0) begin
                check("n2_ack",  100 + k, {30'd0, ack2},  32'd2);
                check("n2_push", 100 + k, {31'd0, push2}, 32'd0);
            end else begin
                check("n2_ack",  100 + k, {30'd0, ack2},  32'd0);
                check("n2_push", 100 + k, {31'd0, push2}, 32'd1);
                check("n2_data", 100 + k, wdata2,         32'hCAFE0042);
                check("n2_index",100 + k, {24'd0, widx2}, 32'd9);
            end
            @(posedge clk);
            #1;
        end
        v2 = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_varint_arb
